// File: rtl/dance_pkg.sv
// dance_pkg: game states, one-hot lane constants and lane index/one-hot helpers
package dance_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, COUNTDOWN = 2'd1, PLAYING = 2'd2, DONE = 2'd3} game_state_t;
   localparam logic [3:0] LANE0 = 4'b0001;
   localparam logic [3:0] LANE1 = 4'b0010;
   localparam logic [3:0] LANE2 = 4'b0100;
   localparam logic [3:0] LANE3 = 4'b1000;
   function automatic logic [3:0] lane_encode(input logic [1:0] idx);
      return LANE0 << idx;
   endfunction
   function automatic logic [1:0] lane_decode(input logic [3:0] lane);
      return lane[3] ? 2'd3 : lane[2] ? 2'd2 : lane[1] ? 2'd1 : 2'd0;
   endfunction
   function automatic logic is_onehot(input logic [3:0] lane);
      return lane != 4'd0 && (lane & (lane - 4'd1)) == 4'd0;
   endfunction
endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: DEPTH x 2-bit synchronous FIFO of lane indices; push into a full FIFO succeeds only alongside a pop
module lane_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       push,
   input  logic       pop,
   input  logic       clear,
   input  logic [1:0] din,
   output logic       full,
   output logic       empty,
   output logic [1:0] head
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [1:0] mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic [AW:0] count;
   logic do_push, do_pop;
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign full = count == (AW + 1)'(DEPTH);
   assign empty = count == '0;
   assign head = mem[rd];
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   always_ff @(posedge clock) begin
      if (!resetn || clear) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= inc(wr);
         if (do_pop) rd <= inc(rd);
         count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end
   always_ff @(posedge clock)
      if (do_push) mem[wr] <= din;
endmodule

// File: rtl/step_scheduler.sv
// step_scheduler: game FSM (idle/countdown/playing/done), step buffering with drop count,
// and launch of buffered steps into the lowest-index free animator slot
module step_scheduler
   import dance_pkg::*;
#(
   parameter int NUM_SLOTS       = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int SONG_STEPS      = 100,
   parameter int COUNTDOWN_TICKS = 3,
   parameter int TICK_DIV        = 50000000
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 pause,
   input  logic                 step_valid,
   input  logic [3:0]           step_lane,
   input  logic [NUM_SLOTS-1:0] slot_free,
   output logic [NUM_SLOTS-1:0] spawn_valid,
   output logic [3:0]           spawn_lane,
   output logic                 chor_resetn,
   output logic                 chor_run,
   output logic [1:0]           game_state,
   output logic [1:0]           countdown,
   output logic [7:0]           steps_left,
   output logic [7:0]           dropped_count
);
   localparam int TW = $clog2(TICK_DIV);
   game_state_t state, nstate;
   logic [TW-1:0] tick;
   logic [NUM_SLOTS-1:0] avail, grant;
   logic [1:0] head;
   logic full, empty, pop, accept, load, cd_step, tick_wrap, cd_done, fin;
   // a slot granted last cycle still reads free for one cycle, so mask it
   assign avail = slot_free & ~spawn_valid;
   assign grant = avail & (~avail + 1'b1);
   assign pop = state == PLAYING && !pause && !empty && |avail;
   assign accept = state == PLAYING && step_valid && is_onehot(step_lane) && steps_left != 8'd0;
   assign load = start && (state == IDLE || state == DONE);
   assign cd_step = state == COUNTDOWN && !pause;
   assign tick_wrap = tick == TW'(TICK_DIV - 1);
   assign cd_done = cd_step && tick_wrap && countdown == 2'd1;
   assign fin = state == PLAYING && steps_left == 8'd0 && empty && &slot_free && spawn_valid == '0;
   assign nstate = load ? COUNTDOWN : cd_done ? PLAYING : fin ? DONE : state;
   assign game_state = state;
   lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock), .resetn(resetn), .push(accept), .pop(pop), .clear(load),
      .din(lane_decode(step_lane)), .full(full), .empty(empty), .head(head)
   );
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= IDLE;
         tick <= '0;
         countdown <= '0;
         steps_left <= '0;
         dropped_count <= '0;
         spawn_valid <= '0;
         spawn_lane <= '0;
         chor_resetn <= 1'b0;
         chor_run <= 1'b0;
      end else begin
         state <= nstate;
         chor_resetn <= nstate == PLAYING;
         chor_run <= nstate == PLAYING && !pause;
         spawn_valid <= pop ? grant : '0;
         if (pop) spawn_lane <= lane_encode(head);
         if (load) begin
            countdown <= 2'(COUNTDOWN_TICKS);
            tick <= '0;
         end else if (cd_step) begin
            tick <= tick_wrap ? '0 : tick + 1'b1;
            if (tick_wrap) countdown <= countdown - 2'd1;
         end
         if (cd_done) steps_left <= 8'(SONG_STEPS);
         else if (accept) steps_left <= steps_left - 8'd1;
         if (load) dropped_count <= '0;
         else if (accept && full && !pop && dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed scenarios plus randomized play, checked every cycle against a queue-based reference model
module tb_step_scheduler;
   localparam int NS = 4, DEPTH = 4, SS = 100, CT = 3, TD = 4;
   logic clock = 0, resetn = 0, start = 0, pause = 0, step_valid = 0;
   logic [3:0] step_lane = 0, slot_free = 0;
   logic [NS-1:0] spawn_valid;
   logic [3:0] spawn_lane;
   logic chor_resetn, chor_run;
   logic [1:0] game_state, countdown;
   logic [7:0] steps_left, dropped_count;
   int checks = 0, errors = 0;
   int m_state, m_cd, m_tick, m_steps, m_drop, m_sv, m_sl, m_cr, m_run;
   int q[$];

   step_scheduler #(.NUM_SLOTS(NS), .FIFO_DEPTH(DEPTH), .SONG_STEPS(SS), .COUNTDOWN_TICKS(CT), .TICK_DIV(TD)) dut (
      .clock(clock), .resetn(resetn), .start(start), .pause(pause), .step_valid(step_valid),
      .step_lane(step_lane), .slot_free(slot_free), .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
      .chor_resetn(chor_resetn), .chor_run(chor_run), .game_state(game_state), .countdown(countdown),
      .steps_left(steps_left), .dropped_count(dropped_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // next-state of the game as a whole, from the current inputs
   task automatic model_step();
      int avail, g, hd, ns;
      bit popped, full, fin;
      if (!resetn) begin
         m_state = 0; m_cd = 0; m_tick = 0; m_steps = 0; m_drop = 0; m_sv = 0; m_sl = 0;
         q.delete();
      end else begin
         ns = m_state;
         avail = int'(slot_free) & ~m_sv;
         popped = 0;
         g = 0;
         full = q.size() == DEPTH;
         fin = m_state == 2 && m_steps == 0 && q.size() == 0 && slot_free == 4'hF && m_sv == 0;
         if (m_state == 2 && !pause && q.size() > 0 && avail != 0) begin
            while (!avail[g]) g++;
            popped = 1;
            hd = q.pop_front();
            m_sl = 1 << hd;
         end
         m_sv = popped ? (1 << g) : 0;
         if (m_state == 2 && step_valid && $countones(step_lane) == 1 && m_steps > 0) begin
            m_steps--;
            if (!full || popped) q.push_back($clog2(step_lane));
            else if (m_drop < 255) m_drop++;
         end
         if ((m_state == 0 || m_state == 3) && start) begin
            ns = 1; m_cd = CT; m_tick = 0; m_drop = 0;
            q.delete();
         end else if (m_state == 1 && !pause) begin
            if (m_tick == TD - 1) begin
               m_tick = 0;
               m_cd--;
               if (m_cd == 0) begin ns = 2; m_steps = SS; end
            end else m_tick++;
         end else if (fin) ns = 3;
         m_state = ns;
      end
      m_cr = (resetn && m_state == 2) ? 1 : 0;
      m_run = (m_cr && !pause) ? 1 : 0;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clock);
      #1;
      check("game_state", game_state, m_state);
      check("countdown", countdown, m_cd);
      check("steps_left", steps_left, m_steps);
      check("dropped_count", dropped_count, m_drop);
      check("spawn_valid", spawn_valid, m_sv);
      if (m_sv != 0) check("spawn_lane", spawn_lane, m_sl);
      check("chor_resetn", chor_resetn, m_cr);
      check("chor_run", chor_run, m_run);
   endtask

   task automatic step(input logic [3:0] lane);
      step_valid = 1; step_lane = lane;
      cyc();
      step_valid = 0;
   endtask

   task automatic run_to_playing(output int n);
      n = 0;
      start = 1;
      cyc();
      start = 0;
      while (game_state != 2 && n < 40) begin cyc(); n++; end
   endtask

   initial begin
      int n;
      cyc(); cyc();
      check("rst_spawn_lane", spawn_lane, 0);
      check("rst_state", game_state, 0);
      resetn = 1;
      cyc();
      run_to_playing(n);
      check("cd_cycles", n, 12);
      check("play_steps_left", steps_left, 100);
      check("play_chor_resetn", chor_resetn, 1);
      slot_free = 4'hF;
      step_valid = 1; step_lane = 4'b0100;
      cyc();
      step_lane = 4'b0001;
      cyc();
      step_valid = 0;
      check("first_spawn_slot", spawn_valid, 4'b0001);
      check("first_spawn_lane", spawn_lane, 4'b0100);
      cyc();
      check("second_spawn_slot", spawn_valid, 4'b0010);
      check("second_spawn_lane", spawn_lane, 4'b0001);
      slot_free = 0;
      for (int i = 0; i < 6; i++) step(4'b0001 << (i % 4));
      check("drop_count", dropped_count, 2);
      slot_free = 4'b0100;
      cyc();
      check("freed_slot_spawn", spawn_valid, 4'b0100);
      check("freed_slot_lane", spawn_lane, 4'b0001);
      slot_free = 0;
      cyc();
      pause = 1; slot_free = 4'hF;
      repeat (3) cyc();
      check("pause_no_spawn", spawn_valid, 0);
      check("pause_chor_run", chor_run, 0);
      pause = 0;
      cyc();
      check("resume_spawn", spawn_valid, 4'b0001);
      check("resume_lane", spawn_lane, 4'b0010);
      repeat (3) cyc();
      step(4'b0110);
      check("bad_lane_steps_left", steps_left, 92);
      n = 0;
      while (game_state != 3 && n < 3000) begin
         step_valid = $urandom_range(0, 9) < 3;
         step_lane = $urandom_range(0, 6) == 0 ? 4'($urandom_range(0, 15)) : 4'b0001 << $urandom_range(0, 3);
         slot_free = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
         pause = $urandom_range(0, 9) == 0;
         start = $urandom_range(0, 49) == 0;
         cyc();
         n++;
      end
      step_valid = 0; pause = 0; start = 0;
      check("reached_done", game_state, 3);
      check("done_chor_resetn", chor_resetn, 0);
      step(4'b0010);
      check("done_step_ignored", steps_left, 0);
      start = 1;
      cyc();
      start = 0;
      check("restart_state", game_state, 1);
      check("restart_drop", dropped_count, 0);
      check("restart_countdown", countdown, 3);
      while (game_state != 2 && n < 3100) begin cyc(); n++; end
      slot_free = 0;
      for (int i = 0; i < 3; i++) step(4'b1000);
      resetn = 0;
      cyc();
      check("midreset_state", game_state, 0);
      check("midreset_steps", steps_left, 0);
      check("midreset_spawn", spawn_valid, 0);
      check("midreset_chor", chor_resetn, 0);
      resetn = 1;
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/step_scheduler.md
# step_scheduler

Game-level sequencer and slot arbiter between the step choreography generator and the falling-block animators. Runs the game state machine (idle, countdown, playing, done), holds the choreography generator in reset outside play, and buffers incoming one-hot lane steps in a small FIFO. It launches each buffered step into the lowest-index free block slot. Drops are counted and exported to the score and debug display.

## Interface
- NUM_SLOTS, 4: number of falling-block animator slots (1–8)
- FIFO_DEPTH, 4: pending-step buffer depth (power of two)
- SONG_STEPS, 100: steps per song (1–255)
- COUNTDOWN_TICKS, 3: countdown length in ticks (1–3)
- TICK_DIV, 50000000: clock cycles per countdown tick (≥2)
- clock  in  1  system clock; all logic on posedge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  start request; sampled each cycle
- pause  in  1  level; freezes countdown and spawning
- step_valid  in  1  one-cycle pulse: choreography emitted a step
- step_lane  in  4  one-hot lane of that step
- slot_free  in  NUM_SLOTS  per-slot idle flag from animators
- spawn_valid  out  NUM_SLOTS  one-hot, one-cycle launch pulse
- spawn_lane  out  4  one-hot lane for the launched slot
- chor_resetn  out  1  active-low hold for choreography generator
- chor_run  out  1  high when choreography may advance
- game_state  out  2  0 IDLE, 1 COUNTDOWN, 2 PLAYING, 3 DONE
- countdown  out  2  remaining countdown ticks
- steps_left  out  8  song steps not yet received
- dropped_count  out  8  saturating count of dropped steps

## Operation
- Reset (resetn low at an edge): state IDLE, FIFO empty, spawn_valid 0, spawn_lane 0, chor_resetn 0, chor_run 0, countdown 0, steps_left 0, dropped_count 0, tick counter 0.
- IDLE: start → COUNTDOWN; countdown ← COUNTDOWN_TICKS, tick counter ← 0, dropped_count ← 0, FIFO cleared.
- COUNTDOWN: tick counter counts 0..TICK_DIV-1 and holds while pause is high. On wrap, countdown decrements. When countdown would reach 0: go to PLAYING, steps_left ← SONG_STEPS.
- PLAYING: chor_resetn 1; chor_run = !pause.
  - A valid step has step_valid high and step_lane one-hot. Each valid step with steps_left > 0 decrements steps_left.
  - Non-one-hot step_lane is ignored: no push, no decrement, no drop count.
  - Steps received while steps_left = 0 are ignored.
- PLAYING → DONE when steps_left = 0, FIFO empty, all slot_free bits high, and no spawn in flight.
- DONE: chor_resetn 0. start → COUNTDOWN, same loads as from IDLE. start in COUNTDOWN or PLAYING is ignored.
- chor_resetn = 0 and chor_run = 0 in IDLE, COUNTDOWN and DONE.
- FIFO push/drop rules:
  - A valid step is pushed as a 2-bit lane index.
  - If the FIFO is full and not popped in the same cycle, the step is dropped and dropped_count increments, saturating at 255.
  - Push and pop in the same cycle on a full FIFO: both succeed.
- Issue rules:
  - When in PLAYING, pause is low and the FIFO is non-empty, pop the head and grant the lowest-index slot whose slot_free is high.
  - A slot granted in the previous cycle is masked, covering the animator's one-cycle slot_free deassert latency.
  - At most one spawn per cycle. With no eligible slot, the head waits.

## Timing
- Step latency: step_valid sampled at edge E0 (push). Pop and grant decided at E1; spawn_valid and spawn_lane are registered and high for the cycle after E1. Minimum latency is 2 edges.
- A step pushed at E0 is never popped at E0 (no bypass).
- spawn_valid is 0 in every cycle that has no grant. spawn_lane holds its last value but is only meaningful while spawn_valid is high.
- game_state, countdown, steps_left, dropped_count and chor_* are registered and change only at edges.
- Countdown total: COUNTDOWN_TICKS × TICK_DIV unpaused cycles from the start edge to the PLAYING edge.
- resetn low mid-song: all state returns to reset values at that edge; in-flight FIFO contents are discarded.

## Structure
- Shared package dance_pkg:
  - game state enum (IDLE, COUNTDOWN, PLAYING, DONE)
  - one-hot lane constants LANE0..LANE3
  - lane index↔one-hot encode/decode functions, also used by the choreography and animator blocks
- Sub-module lane_fifo: FIFO_DEPTH × 2-bit synchronous FIFO.
  - Inputs: push, pop, clear.
  - Outputs: full, empty, head.
  - Simultaneous push/pop when full is allowed.
- Grant logic is a priority encoder inside step_scheduler.

## Test plan
- Reset then start, TICK_DIV=4, COUNTDOWN_TICKS=3 → PLAYING exactly 12 cycles after the start edge, steps_left=100, chor_resetn rises the same edge.
- step_lane=4'b0100 pulse with all slots free → spawn_valid=4'b0001, spawn_lane=4'b0100 two edges later. A second step the next cycle → slot 1, not slot 0.
- All slot_free low, six valid steps with FIFO_DEPTH=4 → FIFO holds 4, dropped_count=2. Then slot 2 frees → head lane spawns on slot 2.
- pause high with a non-empty FIFO → no spawn_valid and chor_run=0. Release pause → spawns resume next cycle in FIFO order.
- SONG_STEPS=3: three steps spawned and slots return free → DONE, chor_resetn=0. A fourth step in DONE is ignored. start → COUNTDOWN with dropped_count=0.
- step_lane=4'b0110 → no push, steps_left unchanged. resetn low mid-PLAYING → all outputs at reset values next cycle.
